// File: rtl/alu_serial_arbiter_if.sv
// Request/response bundle between requesters and the serial ALU arbiter.
// master = requester/consumer side, slave = arbiter side.
interface alu_serial_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][2:0]  req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic [5:0]       rsp_flags;
    logic             rsp_err;
    logic             rsp_timeout;
    logic             rsp_crc_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data,
        input  rsp_flags, rsp_err, rsp_timeout, rsp_crc_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data,
        output rsp_flags, rsp_err, rsp_timeout, rsp_crc_err
    );
endinterface

// File: rtl/alu_serial_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial ALU link.
// Define ALU_ARB_CRC_CHECK_EN to check the crc3 of returned data frames.
module alu_serial_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_serial_arbiter_if.slave  bus,
    output logic                 sin,
    input  logic                 sout
);

    typedef enum logic [2:0] {IDLE, TX, WAIT_RSP, RX, RESP} state_t;

    // wait_cnt holds the number of cycles since the ctl stop bit
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t       state;
    state_t       state_nx;
    logic         rr_ptr;
    logic         gnt_id;
    logic         accept;
    logic         id_q;
    logic [31:0]  g_a;
    logic [31:0]  g_b;
    logic [2:0]   g_op;
    logic [98:0]  frame_q;
    logic [98:0]  frame_nx;
    logic [6:0]   tx_cnt;
    logic [15:0]  wait_cnt;
    logic         rx_hunt;
    logic         rx_err;
    logic [3:0]   rx_bit;
    logic [2:0]   rx_idx;
    logic [7:0]   rx_sh;
    logic [31:0]  rx_c;
    logic         rx_stop;
    logic         rx_done;
    logic         crc_err_nx;

    function automatic logic [3:0] crc4_f(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic [10:0] byte_f(input logic t, input logic [7:0] d);
        return {1'b0, t, d, 1'b1};
    endfunction

`ifdef ALU_ARB_CRC_CHECK_EN
    function automatic logic [2:0] crc3_f(input logic [36:0] v);
        logic [2:0] c;
        logic       fb;
        c = 3'h0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ v[i];
            c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return c;
    endfunction

    assign crc_err_nx = crc3_f({rx_c, 1'b0, rx_sh[6:3]}) != rx_sh[2:0];
`else
    assign crc_err_nx = 1'b0;
`endif

    // Grant favours rr_ptr and falls back to the other requester
    always_comb begin
        gnt_id = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        accept = (state == IDLE) && (|bus.req_valid) && !rst;
        g_a    = bus.req_a[gnt_id];
        g_b    = bus.req_b[gnt_id];
        g_op   = bus.req_op[gnt_id];
    end

    // Whole 99-bit outgoing frame, first bit on the line at the MSB
    always_comb begin
        frame_nx = {
            byte_f(1'b0, g_b[31:24]), byte_f(1'b0, g_b[23:16]),
            byte_f(1'b0, g_b[15:8]),  byte_f(1'b0, g_b[7:0]),
            byte_f(1'b0, g_a[31:24]), byte_f(1'b0, g_a[23:16]),
            byte_f(1'b0, g_a[15:8]),  byte_f(1'b0, g_a[7:0]),
            byte_f(1'b1, {1'b0, g_op, crc4_f({g_b, g_a, 1'b1, g_op})})
        };
    end

    assign rx_stop = !rx_hunt && (rx_bit == 4'd9);
    assign rx_done = rx_stop && (rx_err || rx_idx == 3'd4);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state plus handshake and serial-line outputs
    always_comb begin
        state_nx      = state;
        bus.req_ready = 2'b00;
        bus.rsp_valid = 1'b0;
        sin           = 1'b1;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    bus.req_ready = gnt_id ? 2'b10 : 2'b01;
                    state_nx      = TX;
                end
            end
            TX: begin
                sin = frame_q[98];
                if (tx_cnt == 7'd98) state_nx = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (!sout)                      state_nx = RX;
                else if (wait_cnt == WAIT_LAST) state_nx = RESP;
            end
            RX: begin
                if (rx_done) state_nx = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: request latch, shifter, timeout counter, receiver, response
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= 1'b0;
            id_q            <= 1'b0;
            frame_q         <= '0;
            tx_cnt          <= '0;
            wait_cnt        <= '0;
            rx_hunt         <= 1'b0;
            rx_err          <= 1'b0;
            rx_bit          <= '0;
            rx_idx          <= '0;
            rx_sh           <= '0;
            rx_c            <= '0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_flags   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_crc_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr  <= ~gnt_id;
                        id_q    <= gnt_id;
                        frame_q <= frame_nx;
                        tx_cnt  <= '0;
                    end
                end
                TX: begin
                    frame_q <= {frame_q[97:0], 1'b1};
                    tx_cnt  <= tx_cnt + 7'd1;
                    if (tx_cnt == 7'd98) wait_cnt <= 16'd1;
                end
                WAIT_RSP: begin
                    if (!sout) begin
                        rx_hunt <= 1'b0;
                        rx_err  <= 1'b0;
                        rx_bit  <= '0;
                        rx_idx  <= '0;
                        rx_c    <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus.rsp_id      <= id_q;
                        bus.rsp_data    <= '0;
                        bus.rsp_flags   <= '0;
                        bus.rsp_err     <= 1'b0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_crc_err <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RX: begin
                    if (rx_hunt) begin
                        if (!sout) begin
                            rx_hunt <= 1'b0;
                            rx_bit  <= '0;
                        end
                    end else begin
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit == 4'd0 && rx_idx == 3'd0) rx_err <= sout;
                        if (rx_bit >= 4'd1 && rx_bit <= 4'd8)
                            rx_sh <= {rx_sh[6:0], sout};
                        if (rx_stop) begin
                            rx_bit <= '0;
                            if (rx_err) begin
                                bus.rsp_id      <= id_q;
                                bus.rsp_data    <= '0;
                                bus.rsp_flags   <= rx_sh[6:1];
                                bus.rsp_err     <= 1'b1;
                                bus.rsp_timeout <= 1'b0;
                                bus.rsp_crc_err <= 1'b0;
                            end else if (rx_idx == 3'd4) begin
                                bus.rsp_id      <= id_q;
                                bus.rsp_data    <= rx_c;
                                bus.rsp_flags   <= {2'b00, rx_sh[6:3]};
                                bus.rsp_err     <= 1'b0;
                                bus.rsp_timeout <= 1'b0;
                                bus.rsp_crc_err <= crc_err_nx;
                            end else begin
                                rx_c    <= {rx_c[23:0], rx_sh};
                                rx_idx  <= rx_idx + 3'd1;
                                rx_hunt <= 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_arbiter.sv
// Directed bench for alu_serial_arbiter with a small serial ALU model.
// Build with ALU_ARB_CRC_CHECK_EN defined to check the crc3 build.
module tb_alu_serial_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic sin;
    logic sout;
    int   errors = 0;
    int   checks = 0;

    alu_serial_arbiter_if bus ();

    alu_serial_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sin  (sin),
        .sout (sout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [98:0] obs, input logic [98:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Remainder of v*x^4 mod (x^4+x+1), by long division
    function automatic logic [3:0] crc4m(input logic [67:0] v);
        logic [71:0] m;
        m = {v, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        return m[3:0];
    endfunction

    // Remainder of v*x^3 mod (x^3+x+1), by long division
    function automatic logic [2:0] crc3m(input logic [36:0] v);
        logic [39:0] m;
        m = {v, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
        return m[2:0];
    endfunction

    function automatic logic [98:0] mk_frame(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        logic [71:0] bytes;
        logic [98:0] f;
        bytes = {b, a, 1'b0, op, crc4m({b, a, 1'b1, op})};
        f = '0;
        for (int i = 8; i >= 0; i--)
            f = {f[87:0], 1'b0, (i == 0), bytes[i*8 +: 8], 1'b1};
        return f;
    endfunction

    task automatic run_tx(input string tag, input logic [1:0] exp_rdy,
                          input logic [98:0] exp_f, output logic [98:0] f);
        #1;
        chk({tag, "_rdy"}, 99'(bus.req_ready), 99'(exp_rdy));
        @(negedge clk);
        chk({tag, "_busy"}, 99'(bus.req_ready), 99'(2'b00));
        for (int i = 98; i >= 0; i--) begin
            f[i] = sin;
            @(negedge clk);
        end
        chk({tag, "_frame"}, f, exp_f);
    endtask

    task automatic alu_byte(input logic t, input logic [7:0] d);
        logic [10:0] s;
        s = {1'b0, t, d, 1'b1};
        for (int i = 10; i >= 0; i--) begin
            sout = s[i];
            @(negedge clk);
        end
    endtask

    task automatic alu_data(input logic [31:0] c, input logic [3:0] fl, input logic [2:0] flip);
        logic [2:0] crc;
        crc = crc3m({c, 1'b0, fl}) ^ flip;
        for (int k = 3; k >= 0; k--) begin
            alu_byte(1'b0, c[k*8 +: 8]);
            repeat (2) @(negedge clk);
        end
        alu_byte(1'b0, {1'b0, fl, crc});
    endtask

    task automatic alu_errf(input logic [5:0] fl);
        alu_byte(1'b1, {1'b0, fl, 1'b0});
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_valid"}, 99'(bus.rsp_valid), 99'(1'b1));
    endtask

    task automatic ack(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_ack"}, 99'(bus.rsp_valid), 99'(1'b0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_sin"},   99'(sin),             99'(1'b1));
        chk({tag, "_rdy"},   99'(bus.req_ready),   99'(2'b00));
        chk({tag, "_vld"},   99'(bus.rsp_valid),   99'(1'b0));
        chk({tag, "_id"},    99'(bus.rsp_id),      99'(1'b0));
        chk({tag, "_data"},  99'(bus.rsp_data),    99'(32'h0));
        chk({tag, "_flags"}, 99'(bus.rsp_flags),   99'(6'h0));
        chk({tag, "_err"},   99'(bus.rsp_err),     99'(1'b0));
        chk({tag, "_to"},    99'(bus.rsp_timeout), 99'(1'b0));
        chk({tag, "_crc"},   99'(bus.rsp_crc_err), 99'(1'b0));
    endtask

    logic [98:0] f;
    logic [98:0] ef;
    logic        exp_crc;

    initial begin
`ifdef ALU_ARB_CRC_CHECK_EN
        exp_crc = 1'b1;
`else
        exp_crc = 1'b0;
`endif
        rst = 1'b1;
        sout = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst0");
        rst = 1'b0;

        // Basic data op from requester 0
        bus.req_a[0] = 32'hFFFF0000;
        bus.req_b[0] = 32'h0F0F0F0F;
        bus.req_op[0] = 3'b000;
        bus.req_valid = 2'b01;
        run_tx("t1", 2'b01, mk_frame(32'hFFFF0000, 32'h0F0F0F0F, 3'b000), f);
        bus.req_valid = 2'b00;
        chk("t1_byte0", 99'(f[98:88]), 99'(11'b00000011111));
        chk("t1_byte4", 99'(f[54:44]), 99'(11'b00111111111));
        chk("t1_idle_sin", 99'(sin), 99'(1'b1));
        alu_data(32'h0F0F0000, 4'b0101, 3'b000);
        wait_valid("t1");
        chk("t1_id",    99'(bus.rsp_id),      99'(1'b0));
        chk("t1_data",  99'(bus.rsp_data),    99'(32'h0F0F0000));
        chk("t1_flags", 99'(bus.rsp_flags),   99'(6'b000101));
        chk("t1_err",   99'(bus.rsp_err),     99'(1'b0));
        chk("t1_crc",   99'(bus.rsp_crc_err), 99'(1'b0));
        bus.req_valid = 2'b11;
        #1;
        chk("t1_no_grant_in_resp", 99'(bus.req_ready), 99'(2'b00));
        repeat (3) @(negedge clk);
        bus.req_valid = 2'b00;
        chk("t1_hold_vld",  99'(bus.rsp_valid), 99'(1'b1));
        chk("t1_hold_data", 99'(bus.rsp_data),  99'(32'h0F0F0000));
        ack("t1");

        // Round-robin with both requesters held valid after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_a[0] = 32'h11111111;
        bus.req_b[0] = 32'h22222222;
        bus.req_op[0] = 3'd1;
        bus.req_a[1] = 32'h33333333;
        bus.req_b[1] = 32'h44444444;
        bus.req_op[1] = 3'd2;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                ef = mk_frame(32'h11111111, 32'h22222222, 3'd1);
                run_tx($sformatf("rr%0d", k), 2'b01, ef, f);
            end else begin
                ef = mk_frame(32'h33333333, 32'h44444444, 3'd2);
                run_tx($sformatf("rr%0d", k), 2'b10, ef, f);
            end
            alu_errf(6'(k + 3));
            wait_valid($sformatf("rr%0d", k));
            chk($sformatf("rr%0d_id", k),    99'(bus.rsp_id),    99'(k % 2));
            chk($sformatf("rr%0d_flags", k), 99'(bus.rsp_flags), 99'(6'(k + 3)));
            ack($sformatf("rr%0d", k));
        end
        bus.req_valid = 2'b00;

        // Timeout: requester 1 alone, ALU silent
        bus.req_a[1] = 32'hA5A5A5A5;
        bus.req_b[1] = 32'h5A5A5A5A;
        bus.req_op[1] = 3'd7;
        bus.req_valid = 2'b10;
        run_tx("to", 2'b10, mk_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd7), f);
        bus.req_valid = 2'b00;
        chk("to_sin_idle", 99'(sin), 99'(1'b1));
        repeat (62) @(negedge clk);
        chk("to_not_yet", 99'(bus.rsp_valid), 99'(1'b0));
        @(negedge clk);
        chk("to_valid",   99'(bus.rsp_valid),   99'(1'b1));
        chk("to_flag",    99'(bus.rsp_timeout), 99'(1'b1));
        chk("to_id",      99'(bus.rsp_id),      99'(1'b1));
        chk("to_data",    99'(bus.rsp_data),    99'(32'h0));
        chk("to_flags",   99'(bus.rsp_flags),   99'(6'h0));
        chk("to_err",     99'(bus.rsp_err),     99'(1'b0));
        ack("to");

        // Error frame, accepted right after the timeout response
        bus.req_a[0] = 32'h00000001;
        bus.req_b[0] = 32'h80000000;
        bus.req_op[0] = 3'd5;
        bus.req_valid = 2'b01;
        run_tx("ef", 2'b01, mk_frame(32'h00000001, 32'h80000000, 3'd5), f);
        bus.req_valid = 2'b00;
        alu_errf(6'b100101);
        wait_valid("ef");
        chk("ef_err",   99'(bus.rsp_err),     99'(1'b1));
        chk("ef_flags", 99'(bus.rsp_flags),   99'(6'b100101));
        chk("ef_data",  99'(bus.rsp_data),    99'(32'h0));
        chk("ef_id",    99'(bus.rsp_id),      99'(1'b0));
        chk("ef_to",    99'(bus.rsp_timeout), 99'(1'b0));
        ack("ef");

        // Corrupted crc3; pointer now favours requester 1
        bus.req_a[1] = 32'hCAFEF00D;
        bus.req_b[1] = 32'h01234567;
        bus.req_op[1] = 3'd3;
        bus.req_valid = 2'b11;
        run_tx("cr", 2'b10, mk_frame(32'hCAFEF00D, 32'h01234567, 3'd3), f);
        bus.req_valid = 2'b00;
        alu_data(32'hDEADBEEF, 4'b1010, 3'b001);
        wait_valid("cr");
        chk("cr_data",  99'(bus.rsp_data),    99'(32'hDEADBEEF));
        chk("cr_flags", 99'(bus.rsp_flags),   99'(6'b001010));
        chk("cr_crc",   99'(bus.rsp_crc_err), 99'(exp_crc));
        chk("cr_err",   99'(bus.rsp_err),     99'(1'b0));
        chk("cr_id",    99'(bus.rsp_id),      99'(1'b1));
        ack("cr");

        // Reset in the middle of a transmit, then a clean req1
        bus.req_a[0] = 32'h76543210;
        bus.req_b[0] = 32'hFEDCBA98;
        bus.req_op[0] = 3'd6;
        bus.req_valid = 2'b01;
        ef = mk_frame(32'h76543210, 32'hFEDCBA98, 3'd6);
        #1;
        chk("mr_rdy", 99'(bus.req_ready), 99'(2'b01));
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (40) @(negedge clk);
        chk("mr_bit40", 99'(sin), 99'(ef[58]));
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs("mr");
        rst = 1'b0;
        @(negedge clk);
        chk("mr_sin_after", 99'(sin), 99'(1'b1));
        bus.req_a[1] = 32'h0000FFFF;
        bus.req_b[1] = 32'h12121212;
        bus.req_op[1] = 3'd4;
        bus.req_valid = 2'b10;
        run_tx("mr", 2'b10, mk_frame(32'h0000FFFF, 32'h12121212, 3'd4), f);
        bus.req_valid = 2'b00;
        alu_data(32'h12345678, 4'b0011, 3'b000);
        wait_valid("mr");
        chk("mr_id",   99'(bus.rsp_id),      99'(1'b1));
        chk("mr_data", 99'(bus.rsp_data),    99'(32'h12345678));
        chk("mr_crc",  99'(bus.rsp_crc_err), 99'(1'b0));
        ack("mr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
